usb_rx_bit_timer: RTL and testbench

- Upstream stage of the RX byte counter in the USB CDL receiver.
- Recovers bit timing from the synchronized D+/D- lines and NRZI-decodes each bit.
- Removes stuffed bits and flags EOP and stuffing errors.
- Emits a one-cycle shift_enable per real data bit; the RX shift register and the byte counter's count_enable consume it.

---
 rtl/usb_rx_bit_timer.sv | 127 ++++++++++++
 tb/tb_usb_rx_bit_timer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/usb_rx_bit_timer.sv
// USB RX bit timer: recovers bit timing from the synchronized D+/D- lines,
// NRZI-decodes each sampled bit, drops stuffed bits, and flags EOP (SE0)
// and bit-stuffing violations. All outputs are registered one-cycle pulses.
module usb_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_PHASE = 3,
    parameter int unsigned MAX_ONES     = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic enable_timer,
    input  logic d_plus_sync,
    input  logic d_minus_sync,
    output logic shift_enable,
    output logic d_orig,
    output logic stuff_err,
    output logic eop
);

    localparam int unsigned PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PHASE_LAST   = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_PHASE);
    localparam logic [2:0]    ONES_LIMIT   = 3'(MAX_ONES);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state, state_next;
    logic [PW-1:0] phase, phase_next;
    logic [2:0]    ones_cnt, ones_next;
    logic          last_level, last_level_next;
    logic          d_plus_prev;

    logic          line_edge;
    logic          se0;
    logic          bit_val;
    logic          sample;
    logic          shift_next, d_orig_next, stuff_err_next, eop_next;

    assign line_edge = (d_plus_sync != d_plus_prev);
    assign se0       = !d_plus_sync && !d_minus_sync;
    assign bit_val   = (d_plus_sync == last_level);
    // An edge on the would-be sample cycle resynchronizes instead of sampling.
    assign sample    = (state == RUN) && enable_timer && (phase == PHASE_SAMPLE) && !line_edge;

    // Line history for edge detection, tracked regardless of enable.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_plus_prev <= 1'b1;
        end else begin
            d_plus_prev <= d_plus_sync;
        end
    end

    // State, timing and decode registers plus registered output pulses.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            phase        <= '0;
            ones_cnt     <= '0;
            last_level   <= 1'b1;
            shift_enable <= 1'b0;
            d_orig       <= 1'b0;
            stuff_err    <= 1'b0;
            eop          <= 1'b0;
        end else begin
            state        <= state_next;
            phase        <= phase_next;
            ones_cnt     <= ones_next;
            last_level   <= last_level_next;
            shift_enable <= shift_next;
            d_orig       <= d_orig_next;
            stuff_err    <= stuff_err_next;
            eop          <= eop_next;
        end
    end

    // Next-state, phase tracking and sample decode.
    always_comb begin
        state_next      = state;
        phase_next      = phase;
        ones_next       = ones_cnt;
        last_level_next = last_level;
        shift_next      = 1'b0;
        d_orig_next     = 1'b0;
        stuff_err_next  = 1'b0;
        eop_next        = 1'b0;

        if (!enable_timer) begin
            // Idle (or leaving RUN): park the timing and decode registers.
            state_next      = IDLE;
            phase_next      = '0;
            ones_next       = '0;
            last_level_next = 1'b1;
        end else begin
            // The enabling cycle already advances phase so an edge there is phase 0.
            state_next = RUN;
            if (line_edge) begin
                phase_next = PW'(1);
            end else if (phase == PHASE_LAST) begin
                phase_next = '0;
            end else begin
                phase_next = phase + PW'(1);
            end

            if (sample) begin
                if (se0) begin
                    eop_next  = 1'b1;
                    ones_next = '0;
                end else begin
                    last_level_next = d_plus_sync;
                    if (ones_cnt == ONES_LIMIT) begin
                        stuff_err_next = bit_val;
                        ones_next      = '0;
                    end else begin
                        shift_next  = 1'b1;
                        d_orig_next = bit_val;
                        ones_next   = bit_val ? (ones_cnt + 3'd1) : 3'd0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Directed bench for usb_rx_bit_timer: drives NRZI line levels bit by bit
// and checks the four output pulses on every cycle against hand-computed
// expectations.
module tb_usb_rx_bit_timer;

    localparam logic [1:0] LJ   = 2'b10;   // {D+, D-} idle J
    localparam logic [1:0] LK   = 2'b01;   // K
    localparam logic [1:0] LSE0 = 2'b00;   // single-ended zero

    // Expected {shift_enable, d_orig, stuff_err, eop}
    localparam logic [3:0] V_NONE = 4'b0000;
    localparam logic [3:0] V_D0   = 4'b1000;
    localparam logic [3:0] V_D1   = 4'b1100;
    localparam logic [3:0] V_SERR = 4'b0010;
    localparam logic [3:0] V_EOP  = 4'b0001;

    localparam int unsigned NO_HIT = 99;

    logic clk;
    logic n_rst;
    logic enable_timer;
    logic d_plus_sync;
    logic d_minus_sync;
    logic shift_enable;
    logic d_orig;
    logic stuff_err;
    logic eop;

    int checks;
    int failures;

    usb_rx_bit_timer #(
        .CLKS_PER_BIT(8),
        .SAMPLE_PHASE(3),
        .MAX_ONES(6)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .enable_timer(enable_timer),
        .d_plus_sync (d_plus_sync),
        .d_minus_sync(d_minus_sync),
        .shift_enable(shift_enable),
        .d_orig      (d_orig),
        .stuff_err   (stuff_err),
        .eop         (eop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] exp_vec);
        logic [3:0] obs;
        obs = {shift_enable, d_orig, stuff_err, eop};
        checks++;
        assert (obs === exp_vec) else begin
            failures++;
            $error("FAIL %s: observed=%b expected=%b (se,d,err,eop) t=%0t", tag, obs, exp_vec, $time);
        end
    endtask

    // Hold one line level for len cycles; the pulse is expected right after
    // cycle index hit, all outputs low on every other cycle.
    task automatic send_bit(input logic [1:0] line, input int unsigned len,
                            input int unsigned hit, input logic [3:0] exp_vec,
                            input string tag);
        for (int unsigned j = 0; j < len; j++) begin
            {d_plus_sync, d_minus_sync} = line;
            @(posedge clk);
            #1;
            check(tag, (j == hit) ? exp_vec : V_NONE);
        end
    endtask

    task automatic random_reset_cycle(input string tag);
        d_plus_sync  = 1'($urandom_range(1, 0));
        d_minus_sync = 1'($urandom_range(1, 0));
        enable_timer = 1'($urandom_range(1, 0));
        @(posedge clk);
        #1;
        check(tag, V_NONE);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        n_rst        = 1'b0;
        enable_timer = 1'b0;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;

        // Reset with random line activity, then release with the timer disabled.
        for (int i = 0; i < 6; i++) random_reset_cycle("reset_hold");
        enable_timer = 1'b0;
        n_rst        = 1'b1;
        for (int i = 0; i < 10; i++) begin
            d_plus_sync  = 1'($urandom_range(1, 0));
            d_minus_sync = 1'($urandom_range(1, 0));
            @(posedge clk);
            #1;
            check("released_disabled", V_NONE);
        end
        send_bit(LJ, 2, NO_HIT, V_NONE, "idle_j");

        // SYNC: KJKJKJKK, enable rises with the first K.
        enable_timer = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_bit(LK, 8, 3, V_D0, "sync_k");
            send_bit(LJ, 8, 3, V_D0, "sync_j");
        end
        send_bit(LK, 8, 3, V_D0, "sync_k7");
        send_bit(LK, 8, 3, V_D1, "sync_k8");

        // 0x7E then 0xFF, LSB first, stuffed 0 after every sixth 1.
        send_bit(LJ, 8, 3, V_D0, "x7e_b0");
        for (int i = 0; i < 6; i++) send_bit(LJ, 8, 3, V_D1, "x7e_ones");
        send_bit(LK, 8, 3, V_NONE, "x7e_stuffed");
        send_bit(LJ, 8, 3, V_D0, "x7e_b7");
        for (int i = 0; i < 6; i++) send_bit(LJ, 8, 3, V_D1, "xff_ones");
        send_bit(LK, 8, 3, V_NONE, "xff_stuffed");
        send_bit(LK, 8, 3, V_D1, "xff_b6");
        send_bit(LK, 8, 3, V_D1, "xff_b7");

        // Stuff error: run of ones (two carried) reaches six, seventh has no transition.
        for (int i = 0; i < 4; i++) send_bit(LK, 8, 3, V_D1, "serr_ones");
        send_bit(LK, 8, 3, V_SERR, "serr_pulse");
        for (int i = 0; i < 6; i++) send_bit(LK, 8, 3, V_D1, "serr_count_cleared");
        send_bit(LJ, 8, 3, V_NONE, "serr_then_stuffed");

        // EOP: two SE0 periods then J (last level is still J, decodes as 1).
        send_bit(LSE0, 8, 3, V_EOP, "eop_1");
        send_bit(LSE0, 8, 3, V_EOP, "eop_2");
        send_bit(LJ, 8, 3, V_D1, "eop_then_j");
        enable_timer = 1'b0;
        send_bit(LJ, 6, NO_HIT, V_NONE, "disabled_idle");

        // Resync: restored last level J makes the first K a 0; early and late edges.
        enable_timer = 1'b1;
        send_bit(LK, 6, 3, V_D0, "jit_early_k");
        send_bit(LJ, 10, 3, V_D0, "jit_late_j");
        send_bit(LK, 8, 3, V_D0, "jit_after_k");
        // Short J whose end edge falls on the sample phase: neither it nor the edge is sampled.
        send_bit(LJ, 3, NO_HIT, V_NONE, "edge_on_sample_j");
        send_bit(LK, 8, 3, V_D1, "edge_on_sample_k");

        // Enable drops before the sample point of a bit.
        send_bit(LK, 2, NO_HIT, V_NONE, "abort_pre");
        enable_timer = 1'b0;
        send_bit(LK, 8, NO_HIT, V_NONE, "abort_post");

        // Reset asserted at phase 5 mid-packet.
        enable_timer = 1'b1;
        send_bit(LJ, 5, 3, V_D1, "prereset_j");
        n_rst = 1'b0;
        #2;
        check("reset_async", V_NONE);
        for (int i = 0; i < 2; i++) random_reset_cycle("reset_mid");
        enable_timer = 1'b0;
        d_plus_sync  = 1'b1;
        d_minus_sync = 1'b0;
        n_rst        = 1'b1;
        send_bit(LJ, 16, NO_HIT, V_NONE, "post_reset_quiet");
        enable_timer = 1'b1;
        send_bit(LK, 8, 3, V_D0, "post_reset_k");
        enable_timer = 1'b0;
        send_bit(LK, 4, NO_HIT, V_NONE, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
